// File: rtl/spi_host_pkg.sv
// Shared types and sizing helpers for the SPI mode-0 host.
package spi_host_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_NEXT, HOLD, GAP} state_t;

  localparam int XLEN_DEF    = 32;
  localparam int CLK_DIV_DEF = 4;
  localparam int CLK_DIV_MIN = 3;

  function automatic int half_cnt_w(input int clk_div);
    return $clog2(clk_div);
  endfunction

  function automatic int bit_cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit, clears to 0.
module sync_2ff (
  input  logic CLK,
  input  logic RVRSTN,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge CLK or negedge RVRSTN) begin
    if (!RVRSTN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spi_host.sv
// SPI mode-0 master: shifts XLEN-bit words MSB-first, returns the MISO word on a strobe.
// CS may stay low across words (WAIT_NEXT); HOLD/GAP frame the release of CS.
module spi_host
  import spi_host_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic            CLK,
  input  logic            RVRSTN,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_data_i,
  input  logic            req_last_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o,
  output logic            SCLK_O,
  output logic            CS_O,
  output logic            MOSI_O,
  input  logic            MISO_I
);

  localparam int HW = half_cnt_w(CLK_DIV);
  localparam int BW = bit_cnt_w(XLEN);
  localparam logic [HW-1:0] HALF_MAX = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(XLEN - 1);

  if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
    $error("spi_host: CLK_DIV must be at least 3");
  end

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q;
  logic [BW-1:0]   bcnt_q;
  logic [XLEN-2:0] shreg_q;
  logic [XLEN-2:0] cap_q;
  logic            last_q;
  logic            sclk_q, cs_q, mosi_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            miso_s;
  logic            hs, half_done, fall, last_fall;

  sync_2ff u_miso_sync (
    .CLK    (CLK),
    .RVRSTN (RVRSTN),
    .d      (MISO_I),
    .q      (miso_s)
  );

  assign req_ready_o = RVRSTN && (state_q == IDLE || state_q == WAIT_NEXT);
  assign hs          = req_valid_i && req_ready_o;
  assign half_done   = (hcnt_q == HALF_MAX);
  assign fall        = (state_q == SHIFT) && half_done && sclk_q;
  assign last_fall   = fall && (bcnt_q == BIT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hs) state_d = SHIFT;
      SHIFT:     if (last_fall) state_d = last_q ? HOLD : WAIT_NEXT;
      WAIT_NEXT: if (hs) state_d = SHIFT;
      HOLD:      if (half_done) state_d = GAP;
      GAP:       if (half_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RVRSTN) begin
    if (!RVRSTN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RVRSTN) begin
    if (!RVRSTN) begin
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      cap_q       <= '0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (hs) begin
        hcnt_q  <= '0;
        bcnt_q  <= '0;
        shreg_q <= req_data_i[XLEN-2:0];
        last_q  <= req_last_i;
        mosi_q  <= req_data_i[XLEN-1];
        cs_q    <= 1'b0;
        sclk_q  <= 1'b0;
      end else if (state_q inside {SHIFT, HOLD, GAP}) begin
        // The half-period counter also times HOLD and GAP; it wraps to 0 on each state entry.
        hcnt_q <= half_done ? '0 : hcnt_q + 1'b1;
        if (state_q == SHIFT && half_done) sclk_q <= ~sclk_q;
        if (fall) begin
          bcnt_q <= bcnt_q + 1'b1;
          cap_q  <= {cap_q[XLEN-3:0], miso_s};
          if (last_fall) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= {cap_q, miso_s};
          end else begin
            mosi_q  <= shreg_q[XLEN-2];
            shreg_q <= {shreg_q[XLEN-3:0], 1'b0};
          end
        end
        if (state_q == HOLD && half_done) cs_q <= 1'b1;
      end
    end
  end

  assign SCLK_O      = sclk_q;
  assign CS_O        = cs_q;
  assign MOSI_O      = mosi_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host: behavioural mode-0 slaves, response/MOSI scoreboards, cycle-exact timing.
module tb_spi_host;

  logic CLK = 1'b0;
  logic RVRSTN = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Instance with CLK_DIV=4
  logic        req_valid = 1'b0, req_ready, req_last = 1'b0;
  logic [31:0] req_data = '0, rsp_data;
  logic        rsp_valid, busy, sclk, cs, mosi, miso = 1'b0;

  // Instance with CLK_DIV=3
  logic        req_valid3 = 1'b0, req_ready3, req_last3 = 1'b0;
  logic [31:0] req_data3 = '0, rsp_data3;
  logic        rsp_valid3, busy3, sclk3, cs3, mosi3, miso3 = 1'b0;

  spi_host #(.XLEN(32), .CLK_DIV(4)) dut (
    .CLK(CLK), .RVRSTN(RVRSTN),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data), .req_last_i(req_last),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .SCLK_O(sclk), .CS_O(cs), .MOSI_O(mosi), .MISO_I(miso)
  );

  spi_host #(.XLEN(32), .CLK_DIV(3)) dut3 (
    .CLK(CLK), .RVRSTN(RVRSTN),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_data_i(req_data3), .req_last_i(req_last3),
    .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3), .busy_o(busy3),
    .SCLK_O(sclk3), .CS_O(cs3), .MOSI_O(mosi3), .MISO_I(miso3)
  );

  logic [31:0] exp_rsp[$], got_rsp[$], exp_mosi[$], got_rx[$], exp_rsp3[$], got_rsp3[$];
  int          got_cyc[$], got_cyc3[$];
  int          errors = 0, checks = 0;

  logic        sclk_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0;
  int          sclk_tog = 0, cs_tog = 0, mosi_tog = 0, sclk_rise = 0, cs_rise = 0;
  logic [31:0] slave_tx = '0, s_cur = '0, s_rx = '0;
  int          s_idx = 0, s_ridx = 0;

  // Monitor plus a mode-0 slave that updates MISO half a CLK after each SCLK fall.
  always @(negedge CLK) begin
    if (rsp_valid)  begin got_rsp.push_back(rsp_data);   got_cyc.push_back(cyc);  end
    if (rsp_valid3) begin got_rsp3.push_back(rsp_data3); got_cyc3.push_back(cyc); end
    if (sclk !== sclk_p) sclk_tog++;
    if (sclk && !sclk_p) sclk_rise++;
    if (cs !== cs_p) cs_tog++;
    if (cs && !cs_p) cs_rise++;
    if (mosi !== mosi_p) mosi_tog++;
    if (cs_p && !cs) begin
      s_cur = slave_tx; s_idx = 0; s_ridx = 0; miso = slave_tx[31];
    end else if (!cs) begin
      if (sclk && !sclk_p) begin
        s_rx = {s_rx[30:0], mosi};
        s_ridx++;
        if (s_ridx == 32) begin got_rx.push_back(s_rx); s_ridx = 0; end
      end
      if (!sclk && sclk_p) begin
        s_idx++;
        if (s_idx == 32) begin s_cur = ~s_cur; s_idx = 0; end
        miso = s_cur[31 - s_idx];
      end
    end
    sclk_p = sclk; cs_p = cs; mosi_p = mosi;
  end

  // Slave for the CLK_DIV=3 instance: starts at 1, toggles one CLK after every SCLK fall.
  logic cs3_last = 1'b1;
  always @(cs3 or negedge sclk3) begin
    if (cs3_last && !cs3) miso3 = 1'b1;
    else if (!cs3 && !cs3_last) begin @(posedge CLK); #1 miso3 = ~miso3; end
    cs3_last = cs3;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input bit keep, output int t);
    req_valid = 1'b1; req_data = d; req_last = l; t = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin t = cyc; break; end
      tick();
    end
    chk("handshake", 64'(t >= 0), 64'd1);
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int t);
    logic [31:0] g, e;
    int gc;
    for (int i = 0; i < 600 && got_rsp.size() == 0; i++) tick();
    if (got_rsp.size() == 0) chk({tag, "_rsp_timeout"}, 64'(got_rsp.size()), 64'd1);
    else begin
      g = got_rsp.pop_front(); gc = got_cyc.pop_front(); e = exp_rsp.pop_front();
      chk({tag, "_rsp_data"}, g, e);
      chk({tag, "_rsp_cycle"}, gc, t + 257);
    end
  endtask

  task automatic expect_rx(input string tag);
    logic [31:0] g, e;
    g = 'x;
    if (got_rx.size() != 0) g = got_rx.pop_front();
    e = exp_mosi.pop_front();
    chk({tag, "_mosi_word"}, g, e);
  endtask

  initial begin
    int t, t2, base, r0;
    bit ok;

    // Reset values
    tick(3);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs", cs, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    RVRSTN = 1'b1;
    tick();
    chk("idle_ready", req_ready, 1);
    base = sclk_tog + cs_tog + mosi_tog;
    tick(1000);
    chk("idle_no_toggle", sclk_tog + cs_tog + mosi_tog - base, 0);

    // Single word, last=1
    slave_tx = 32'h1234_5678;
    exp_rsp.push_back(32'h1234_5678); exp_mosi.push_back(32'hA5C3_0F81);
    send(32'hA5C3_0F81, 1'b1, 1'b0, t);
    chk("w1_cs_low_t1", cs, 0);
    chk("w1_mosi_msb_t1", mosi, 1);
    chk("w1_busy", busy, 1);
    expect_rsp("w1", t);
    for (int i = 0; i < 50 && !cs; i++) tick();
    chk("w1_cs_rise_cycle", cyc, t + 261);
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    chk("w1_ready_cycle", cyc, t + 265);
    expect_rx("w1");

    // Two-word frame, second request 20 cycles late
    slave_tx = 32'hCAFE_F00D;
    r0 = cs_rise;
    exp_rsp.push_back(32'hCAFE_F00D);  exp_mosi.push_back(32'hDEAD_BEEF);
    exp_rsp.push_back(32'h3501_0FF2);  exp_mosi.push_back(32'h0000_0001);
    send(32'hDEAD_BEEF, 1'b0, 1'b0, t);
    expect_rsp("f1", t);
    chk("f_wait_ready", req_ready, 1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok &= (sclk === 1'b0) && (cs === 1'b0) && (req_ready === 1'b1);
      tick();
    end
    chk("f_wait_next_idle_pins", ok, 1);
    send(32'h0000_0001, 1'b1, 1'b0, t2);
    expect_rsp("f2", t2);
    for (int i = 0; i < 50 && !cs; i++) tick();
    chk("f_cs_rise_cycle", cyc, t2 + 261);
    chk("f_cs_rises", cs_rise - r0, 1);
    expect_rx("f1");
    expect_rx("f2");

    // CLK_DIV=3 instance, alternating MISO
    exp_rsp3.push_back(32'hAAAA_AAAA);
    req_valid3 = 1'b1; req_data3 = 32'h8000_0001; req_last3 = 1'b1; t = -1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready3) begin t = cyc; break; end
      tick();
    end
    tick();
    req_valid3 = 1'b0;
    chk("d3_mosi_msb", mosi3, 1);
    chk("d3_busy", busy3, 1);
    for (int i = 0; i < 400 && got_rsp3.size() == 0; i++) tick();
    if (got_rsp3.size() == 0) chk("d3_rsp_timeout", 64'(got_rsp3.size()), 64'd1);
    else begin
      chk("d3_rsp_data", got_rsp3.pop_front(), exp_rsp3.pop_front());
      chk("d3_rsp_cycle", got_cyc3.pop_front(), t + 193);
    end

    // Reset in the middle of a word
    slave_tx = 32'h0F0F_1234;
    r0 = sclk_rise;
    send(32'h1357_9BDF, 1'b1, 1'b0, t);
    for (int i = 0; i < 200 && sclk_rise < r0 + 11; i++) tick();
    chk("rst_mid_rise10_cycle", cyc, t + 85);
    tick();
    RVRSTN = 1'b0;
    #1;
    chk("rst_mid_cs", cs, 1);
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_ready", req_ready, 0);
    tick(5);
    RVRSTN = 1'b1;
    tick(300);
    chk("rst_mid_no_rsp", got_rsp.size(), 0);
    chk("rst_mid_no_rx", got_rx.size(), 0);
    exp_rsp.push_back(32'h0F0F_1234); exp_mosi.push_back(32'hFFFF_0000);
    send(32'hFFFF_0000, 1'b1, 1'b0, t);
    expect_rsp("post_rst", t);
    expect_rx("post_rst");
    tick(10);

    // req_valid held high through SHIFT/HOLD/GAP with changing data
    slave_tx = 32'h600D_F00D;
    exp_rsp.push_back(32'h600D_F00D); exp_mosi.push_back(32'h3C3C_A5A5);
    exp_rsp.push_back(32'h600D_F00D); exp_mosi.push_back(32'h7E81_18E7);
    send(32'h3C3C_A5A5, 1'b1, 1'b1, t);
    for (int i = 0; i < 400; i++) begin
      if (req_ready) break;
      req_data = $urandom;
      req_last = 1'($urandom);
      tick();
    end
    chk("hv_first_ready_cycle", cyc, t + 265);
    req_data = 32'h7E81_18E7; req_last = 1'b1; t2 = cyc;
    tick();
    req_data = $urandom;
    tick(30);
    req_valid = 1'b0;
    expect_rsp("hv1", t);
    expect_rsp("hv2", t2);
    expect_rx("hv1");
    expect_rx("hv2");

    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_host.md
# spi_host

SPI mode-0 master that drives the chip's SPI slave pins (SCLK, CS, MOSI) and captures MISO, so the SPI load/debug path can be exercised from a second core instance on the FPGA harness and from on-chip bring-up logic. It accepts XLEN-bit words over a valid/ready request port and shifts them out MSB-first. It returns the simultaneously captured MISO word on a response strobe. CS can be held low across consecutive words to form multi-word frames.

## Interface
- XLEN, 32, word length in bits; also the number of SCLK cycles per word.
- CLK_DIV, 4, SCLK half-period in CLK cycles; legal range is 3 or greater, and elaboration fails below 3.
- CLK  input  1  system clock; all logic is on the rising edge.
- RVRSTN  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request word valid.
- req_ready_o  output  1  block can accept a request.
- req_data_i  input  XLEN  word to transmit, MSB first.
- req_last_i  input  1  1: release CS after this word; 0: keep CS low for the next word.
- rsp_valid_o  output  1  single-cycle strobe; rsp_data_o is valid in that cycle.
- rsp_data_o  output  XLEN  word captured from MISO, MSB first.
- busy_o  output  1  1 whenever CS_O is low or the inter-frame gap is running.
- SCLK_O  output  1  SPI clock; idle low (CPOL=0).
- CS_O  output  1  chip select, active-low.
- MOSI_O  output  1  serial data out.
- MISO_I  input  1  serial data in; asynchronous to CLK.

## Operation
- Reset values: SCLK_O=0, CS_O=1, MOSI_O=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, state=IDLE. Asynchronous assertion takes effect immediately, including mid-word. No partial response is emitted.
- req_ready_o is 1 only in IDLE and WAIT_NEXT, and is 0 while RVRSTN is low.
- A handshake occurs when req_valid_i and req_ready_o are both 1. On a handshake the block latches req_data_i into the shift register and req_last_i into last_q.
- States:
  - IDLE: CS_O=1. A handshake moves to SHIFT.
  - SHIFT: CS_O=0. SCLK_O toggles every CLK_DIV cycles, beginning low. After the XLEN-th falling edge:
    - last_q=1 moves to HOLD.
    - last_q=0 moves to WAIT_NEXT.
  - WAIT_NEXT: CS_O=0 and SCLK_O=0. A handshake moves to SHIFT. There is no timeout.
  - HOLD: CS_O=0 for CLK_DIV cycles, then moves to GAP.
  - GAP: CS_O=1 for CLK_DIV cycles, then moves to IDLE.
- MOSI_O is updated with the next bit in the cycle SCLK_O falls. Bit XLEN-1 is presented in the first SHIFT cycle. After the last falling edge MOSI_O keeps bit 0.
- MISO_I passes through a 2-flop synchronizer. The synchronized value is shifted into the capture register (LSB in) in each cycle SCLK_O falls. This samples MISO as it stood during the high phase, which is why CLK_DIV must be at least 3.
- rsp_valid_o pulses in the cycle of the XLEN-th falling edge. rsp_data_o holds its value until the next response. There is no backpressure on the response.
- Counters:
  - Half-period counter: ceil(log2(CLK_DIV)) bits, counts 0..CLK_DIV-1.
  - Bit counter: ceil(log2(XLEN+1)) bits.
  - Both clear on every handshake.

## Timing
- Let T be the handshake cycle and D = CLK_DIV.
- T+1: CS_O=0 and MOSI_O=data[XLEN-1].
- Rising edge k (k=0..XLEN-1) at T+1+D+2kD. Falling edge k at T+1+2D+2kD.
- Last falling edge and rsp_valid_o at T+1+2·XLEN·D. For D=4 and XLEN=32 this is T+257.
- last=1: CS_O rises at T+1+2·XLEN·D+D (T+261). req_ready_o returns at +2D (T+265).
- last=0: req_ready_o=1 from T+257. A handshake at T' repeats the same timing relative to T'. CS_O never rises between the words.
- Throughput with back-to-back requests in a frame: one word per 2·XLEN·D+1 cycles.

## Structure
- spi_host_pkg:
  - state enum {IDLE, SHIFT, WAIT_NEXT, HOLD, GAP}.
  - Localparams for counter widths.
- One sub-module, sync_2ff (1-bit, reset value 0 on RVRSTN), used for MISO_I.
- Output registers drive SCLK_O, CS_O and MOSI_O directly, so there is no combinational path to the pins.

## Test plan
- Reset, then idle: SCLK_O=0, CS_O=1, MOSI_O=0, req_ready_o=1, and no toggling for 1000 cycles.
- Single word 0xA5C3_0F81 with last=1, behavioural slave returning 0x1234_5678:
  - Slave receives 0xA5C3_0F81.
  - rsp_data_o=0x1234_5678 at T+257.
  - CS_O high at T+261 and req_ready_o high at T+265.
- Two words 0xDEADBEEF (last=0) then 0x0000_0001 (last=1), second request delayed 20 cycles:
  - CS_O stays low throughout.
  - SCLK_O idles low in WAIT_NEXT.
  - Two responses are produced.
- CLK_DIV=3 with the slave driving MISO 1 CLK after each falling edge and alternating 1/0: rsp_data_o=0xAAAA_AAAA.
- RVRSTN low in the cycle after rising edge 10:
  - CS_O=1 and SCLK_O=0 immediately.
  - No rsp_valid_o.
  - After release, a fresh word 0xFFFF_0000 completes correctly.
- req_valid_i held high during SHIFT and GAP: no handshake occurs until req_ready_o=1, and the data is sampled only in the handshake cycle.
